spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_pkg.sv | 23 ++
 rtl/spi_xfer_fifo.sv | 60 ++++++
 rtl/spi_xfer_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_pkg.sv
// spi_xfer_pkg: shared types and constants for the SPI transfer controller.
//   xfer_state_e : controller FSM states
//   DIR_WR/DIR_RD: direction encoding stored with each queued command
//   entry_width(): packed width of one command FIFO entry
//                  {dir, ss, addr, wdata}
package spi_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2
    } xfer_state_e;

    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    function automatic int unsigned entry_width(input int unsigned data_w,
                                                input int unsigned addr_w,
                                                input int unsigned ss_w);
        return 1 + ss_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_xfer_fifo.sv
// spi_xfer_fifo: synchronous command FIFO, DEPTH a power of two (>= 2).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   push, wdata  : write request (ignored when full)
//   pop          : read request (ignored when empty)
//   rdata        : head entry (valid when !empty)
//   full, empty  : occupancy flags
module spi_xfer_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: queues SPI commands and sequences them onto a master core.
// Optional macro: SPI_XFER_CTRL_IRQ_EN registers irq = rd_valid | ovf | tmo;
// when undefined irq is tied low.
// Ports:
//   CLK, PRESETn          : clock, synchronous active-low reset
//   SPE, MSTR             : enable; direction of pushed commands (1 = write)
//   cmd_valid/ready, cmd_wdata/addr/ss : command push handshake
//   m_start, m_wr_rd, m_addr, m_wdata, m_ss_n : master core request
//   TXC, m_rdata          : master core completion and read data
//   rd_valid/ready, rd_data : read-data pop handshake
//   busy, ovf, tmo, clr_err, irq : status, sticky errors and interrupt
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned ADDR_W  = 3,
    parameter  int unsigned NUM_SS  = 4,
    parameter  int unsigned DEPTH   = 4,
    parameter  int unsigned TMO_CYC = 1024,
    localparam int unsigned SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              CLK,
    input  logic              PRESETn,
    input  logic              SPE,
    input  logic              MSTR,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [SS_W-1:0]   cmd_ss,
    output logic              m_start,
    output logic              m_wr_rd,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [NUM_SS-1:0] m_ss_n,
    input  logic              TXC,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              ovf,
    output logic              tmo,
    input  logic              clr_err,
    output logic              irq
);
    localparam int unsigned ENTRY_W = entry_width(DATA_W, ADDR_W, SS_W);
    localparam int unsigned CNT_W   = $clog2(TMO_CYC + 1);

    xfer_state_e       state_q, state_d;
    logic              m_start_q, m_start_d;
    logic              m_wr_rd_q, m_wr_rd_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [NUM_SS-1:0] m_ss_n_q, m_ss_n_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              ovf_set, tmo_set;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
    logic               head_dir;
    logic [SS_W-1:0]    head_ss;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    assign cmd_ready  = !fifo_full;
    assign fifo_wdata = {MSTR, cmd_ss, cmd_addr, cmd_wdata};
    assign {head_dir, head_ss, head_addr, head_wdata} = fifo_rdata;

    spi_xfer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (PRESETn),
        .push  (cmd_valid && cmd_ready),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        m_start_d  = 1'b0;
        m_wr_rd_d  = m_wr_rd_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_ss_n_d   = m_ss_n_q;
        rd_valid_d = rd_valid_q && !rd_ready;
        rd_data_d  = rd_data_q;
        tmo_cnt_d  = '0;
        fifo_pop   = 1'b0;
        ovf_set    = 1'b0;
        tmo_set    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (SPE && !fifo_empty) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!SPE) begin
                    // Abort before popping so the command stays queued.
                    state_d  = ST_IDLE;
                    m_ss_n_d = '1;
                end else begin
                    fifo_pop  = 1'b1;
                    m_wr_rd_d = head_dir;
                    m_addr_d  = head_addr;
                    m_wdata_d = head_wdata;
                    m_start_d = 1'b1;
                    // Out-of-range selects match no bit and leave all high.
                    for (int unsigned i = 0; i < NUM_SS; i++) begin
                        m_ss_n_d[i] = (head_ss != SS_W'(i));
                    end
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!SPE) begin
                    state_d  = ST_IDLE;
                    m_ss_n_d = '1;
                end else if (TXC) begin
                    if (m_wr_rd_q == DIR_RD) begin
                        rd_data_d  = m_rdata;
                        rd_valid_d = 1'b1;
                        ovf_set    = rd_valid_q && !rd_ready;
                    end
                    if (!fifo_empty) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d  = ST_IDLE;
                        m_ss_n_d = '1;
                    end
                end else if (tmo_cnt_q == CNT_W'(TMO_CYC - 1)) begin
                    tmo_set  = 1'b1;
                    state_d  = ST_IDLE;
                    m_ss_n_d = '1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                m_ss_n_d = '1;
            end
        endcase

        ovf_d = ovf_set || (ovf_q && !clr_err);
        tmo_d = tmo_set || (tmo_q && !clr_err);
    end

    always_ff @(posedge CLK) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            m_start_q  <= 1'b0;
            m_wr_rd_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_ss_n_q   <= '1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            m_start_q  <= m_start_d;
            m_wr_rd_q  <= m_wr_rd_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_ss_n_q   <= m_ss_n_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign m_start  = m_start_q;
    assign m_wr_rd  = m_wr_rd_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_ss_n   = m_ss_n_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign ovf      = ovf_q;
    assign tmo      = tmo_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

`ifdef SPI_XFER_CTRL_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = rd_valid_q || ovf_q || tmo_q;
    end

    always_ff @(posedge CLK) begin
        if (!PRESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench for spi_xfer_ctrl (TMO_CYC = 16).
// Expected transfers and read pops are queued by the stimulus and
// consumed by a negedge monitor; irq is modelled in the monitor.
module tb_spi_xfer_ctrl;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned NUM_SS  = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TMO_CYC = 16;
    localparam int unsigned SS_W    = 2;

    logic              CLK, PRESETn, SPE, MSTR;
    logic              cmd_valid, cmd_ready;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] cmd_addr;
    logic [SS_W-1:0]   cmd_ss;
    logic              m_start, m_wr_rd;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [NUM_SS-1:0] m_ss_n;
    logic              TXC;
    logic [DATA_W-1:0] m_rdata;
    logic              rd_valid, rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy, ovf, tmo, clr_err, irq;

    spi_xfer_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_SS  (NUM_SS),
        .DEPTH   (DEPTH),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .CLK       (CLK),
        .PRESETn   (PRESETn),
        .SPE       (SPE),
        .MSTR      (MSTR),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wdata (cmd_wdata),
        .cmd_addr  (cmd_addr),
        .cmd_ss    (cmd_ss),
        .m_start   (m_start),
        .m_wr_rd   (m_wr_rd),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ss_n    (m_ss_n),
        .TXC       (TXC),
        .m_rdata   (m_rdata),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .ovf       (ovf),
        .tmo       (tmo),
        .clr_err   (clr_err),
        .irq       (irq)
    );

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [NUM_SS-1:0] ss_n;
    } xfer_t;

    xfer_t             exp_start_q[$];
    logic [DATA_W-1:0] exp_rd_q[$];
    logic [DATA_W-1:0] resp_words[$];
    xfer_t             mon_e;
    logic [DATA_W-1:0] mon_rd;
    logic              irq_prev = 1'b0;
    int                checks = 0;
    int                errors = 0;
    int                n_starts = 0;
    bit                resp_en = 0;
    int                resp_dly = 5;
    int                txc_cnt = 0;
    time               txc_time = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Slave model: TXC resp_dly cycles after each m_start, with queued read data.
    initial begin
        TXC = 1'b0;
        m_rdata = '0;
        forever begin
            cyc();
            TXC = 1'b0;
            if (txc_cnt > 0) begin
                txc_cnt--;
                if (txc_cnt == 0) begin
                    TXC = 1'b1;
                    txc_time = $time;
                    if (resp_words.size() > 0) m_rdata = resp_words.pop_front();
                    else m_rdata = '0;
                end
            end
            if (m_start && resp_en) txc_cnt = resp_dly;
        end
    end

    // Monitor: consumes scoreboard entries whenever the DUT presents output.
    always @(negedge CLK) begin
        if (PRESETn) begin
            if (m_start) begin
                n_starts++;
                if (exp_start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected: got m_start addr %0h wdata %0h, required none", m_addr, m_wdata);
                end else begin
                    mon_e = exp_start_q.pop_front();
                    chk("start_wr_rd", 64'(m_wr_rd), 64'(mon_e.wr));
                    chk("start_addr",  64'(m_addr),  64'(mon_e.addr));
                    chk("start_wdata", 64'(m_wdata), 64'(mon_e.wdata));
                    chk("start_ss_n",  64'(m_ss_n),  64'(mon_e.ss_n));
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_pop_unexpected: got rd_data %0h, required none", rd_data);
                end else begin
                    mon_rd = exp_rd_q.pop_front();
                    chk("rd_pop_data", 64'(rd_data), 64'(mon_rd));
                end
            end
`ifdef SPI_XFER_CTRL_IRQ_EN
            chk("irq_delayed", 64'(irq), 64'(irq_prev));
`else
            chk("irq_tied", 64'(irq), 64'h0);
`endif
            irq_prev = rd_valid | ovf | tmo;
        end else begin
            irq_prev = 1'b0;
        end
    end

    task automatic push(input logic wr, input logic [ADDR_W-1:0] addr, input logic [SS_W-1:0] ss,
                        input logic [DATA_W-1:0] data, input logic [NUM_SS-1:0] exp_ss_n,
                        input logic acc);
        xfer_t e;
        MSTR      = wr;
        cmd_addr  = addr;
        cmd_ss    = ss;
        cmd_wdata = data;
        cmd_valid = 1'b1;
        chk("cmd_ready", 64'(cmd_ready), 64'(acc));
        if (acc) begin
            e.wr = wr; e.addr = addr; e.wdata = data; e.ss_n = exp_ss_n;
            exp_start_q.push_back(e);
        end
        cyc();
        cmd_valid = 1'b0;
        MSTR = ~wr;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (busy && k < max) begin cyc(); k++; end
        chk("idle_reached", 64'(busy), 64'h0);
    endtask

    task automatic wait_start(input int max);
        int k = 0;
        while (!m_start && k < max) begin cyc(); k++; end
        chk("start_seen", 64'(m_start), 64'h1);
    endtask

    initial begin
        int  k, base;
        bit  gap;
        PRESETn = 1'b0; SPE = 1'b0; MSTR = 1'b0; cmd_valid = 1'b0;
        cmd_wdata = '0; cmd_addr = '0; cmd_ss = '0; rd_ready = 1'b0; clr_err = 1'b0;
        cyc(); cyc();
        chk("rst_m_ss_n",    64'(m_ss_n),    64'hF);
        chk("rst_m_start",   64'(m_start),   64'h0);
        chk("rst_m_wdata",   64'(m_wdata),   64'h0);
        chk("rst_rd_valid",  64'(rd_valid),  64'h0);
        chk("rst_ovf",       64'(ovf),       64'h0);
        chk("rst_tmo",       64'(tmo),       64'h0);
        chk("rst_busy",      64'(busy),      64'h0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("rst_irq",       64'(irq),       64'h0);
        PRESETn = 1'b1;
        cyc();

        // Write path: two writes to slave 1, select held across both.
        SPE = 1'b1; resp_en = 1; resp_dly = 5;
        base = n_starts;
        push(1'b1, 3'd2, 2'd1, 32'hA5A5_0001, 4'b1101, 1'b1);
        push(1'b1, 3'd5, 2'd1, 32'hA5A5_0002, 4'b1101, 1'b1);
        gap = 0; k = 0;
        while (busy && k < 100) begin
            if (n_starts > base && m_ss_n != 4'b1101) gap = 1;
            cyc(); k++;
        end
        chk("wr_idle",       64'(busy),            64'h0);
        chk("wr_ss_held",    64'(gap),             64'h0);
        chk("wr_starts",     64'(n_starts - base), 64'd2);
        chk("wr_ss_release", 64'(m_ss_n),          64'hF);

        // Read path, then overflow on a second unpopped read.
        resp_words.push_back(32'hDEAD_BEEF);
        push(1'b0, 3'd3, 2'd0, 32'h11, 4'b1110, 1'b1);
        k = 0;
        while (!rd_valid && k < 50) begin cyc(); k++; end
        chk("rd_valid1",  64'(rd_valid),          64'h1);
        chk("rd_latency", 64'($time - txc_time),  64'd10);
        chk("rd_data1",   64'(rd_data),           64'hDEAD_BEEF);
        chk("rd_ovf0",    64'(ovf),               64'h0);
        resp_words.push_back(32'hCAFE_F00D);
        push(1'b0, 3'd4, 2'd2, 32'h22, 4'b1011, 1'b1);
        k = 0;
        while (!ovf && k < 50) begin cyc(); k++; end
        chk("ovf_set",   64'(ovf),      64'h1);
        chk("rd_data2",  64'(rd_data),  64'hCAFE_F00D);
        chk("rd_valid2", 64'(rd_valid), 64'h1);
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'h0);
        exp_rd_q.push_back(32'hCAFE_F00D);
        rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
        chk("rd_popped", 64'(rd_valid), 64'h0);
        wait_idle(20);

        // FIFO full: DEPTH pushes accepted, the extra one dropped.
        SPE = 1'b0;
        base = n_starts;
        for (int i = 0; i < int'(DEPTH); i++)
            push(1'b1, 3'(i), 2'd3, 32'hF000_0000 + 32'(i), 4'b0111, 1'b1);
        push(1'b1, 3'd7, 2'd3, 32'hBAD0_0000, 4'b0111, 1'b0);
        chk("full_busy", 64'(busy), 64'h1);
        SPE = 1'b1;
        wait_idle(300);
        chk("full_drain_starts", 64'(n_starts - base), 64'(DEPTH));

        // Timeout: no TXC.
        resp_en = 0;
        cyc();
        push(1'b1, 3'd1, 2'd0, 32'h7777_0000, 4'b1110, 1'b1);
        wait_start(20);
        k = 0;
        while (!tmo && k < 40) begin cyc(); k++; end
        chk("tmo_cycles", 64'(k),      64'd16);
        chk("tmo_ss",     64'(m_ss_n), 64'hF);
        chk("tmo_idle",   64'(busy),   64'h0);
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("tmo_clr", 64'(tmo), 64'h0);

        // Abort: SPE dropped mid-XFER, remaining command kept.
        base = n_starts;
        push(1'b1, 3'd2, 2'd2, 32'h1111_0001, 4'b1011, 1'b1);
        push(1'b1, 3'd3, 2'd2, 32'h1111_0002, 4'b1011, 1'b1);
        wait_start(20);
        cyc(); cyc();
        SPE = 1'b0;
        cyc();
        chk("abort_ss",    64'(m_ss_n),  64'hF);
        chk("abort_start", 64'(m_start), 64'h0);
        chk("abort_kept",  64'(busy),    64'h1);
        resp_en = 1; SPE = 1'b1;
        wait_idle(50);
        chk("abort_resume_starts", 64'(n_starts - base), 64'd2);

        // Reset mid-XFER; the late TXC lands in IDLE and is ignored.
        resp_dly = 6;
        resp_words.push_back(32'h5555_AAAA);
        push(1'b0, 3'd6, 2'd1, 32'h0, 4'b1101, 1'b1);
        wait_start(20);
        cyc();
        PRESETn = 1'b0;
        cyc();
        chk("mid_rst_ss",       64'(m_ss_n),   64'hF);
        chk("mid_rst_start",    64'(m_start),  64'h0);
        chk("mid_rst_addr",     64'(m_addr),   64'h0);
        chk("mid_rst_wr_rd",    64'(m_wr_rd),  64'h0);
        chk("mid_rst_busy",     64'(busy),     64'h0);
        chk("mid_rst_rd_data",  64'(rd_data),  64'h0);
        PRESETn = 1'b1; resp_en = 0;
        repeat (8) cyc();
        chk("late_txc_rd_valid", 64'(rd_valid), 64'h0);
        chk("late_txc_busy",     64'(busy),     64'h0);
        chk("late_txc_rd_data",  64'(rd_data),  64'h0);

        chk("sb_start_empty", 64'(exp_start_q.size()), 64'h0);
        chk("sb_rd_empty",    64'(exp_rd_q.size()),    64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
